vdma_timing_gen: RTL and testbench

Video timing generator that drives the in_vsync/in_hsync/in_de inputs of the VDMA read path (mm_rev) in the display clock domain. It produces the raster sync/active pattern from runtime porch/sync/active configuration and frame/line markers. It also produces h/v position counts for overlay and debug logic. Configuration is shadowed so changes take effect only on a frame boundary.

---
 rtl/vtg_pkg.sv | 40 ++++
 rtl/vtg_wrap_counter.sv | 31 +++
 rtl/vdma_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_vdma_timing_gen.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for the video timing generator.
// Optional pre_de output of the top is built when VTG_PRE_DE_EN is defined.
package vtg_pkg;

    // Width of the shadowed configuration fields; the top's CSIZE follows it.
    localparam int VTG_CSIZE = 16;

    localparam string VTG_POL_POS = "POSITIVE";
    localparam string VTG_POL_NEG = "NEGATIVE";

    typedef enum logic [1:0] {
        VTG_IDLE  = 2'd0,
        VTG_LATCH = 2'd1,
        VTG_RUN   = 2'd2
    } vtg_state_e;

    typedef struct packed {
        logic [VTG_CSIZE-1:0] hactive;
        logic [VTG_CSIZE-1:0] hfp;
        logic [VTG_CSIZE-1:0] hsync_len;
        logic [VTG_CSIZE-1:0] hbp;
        logic [VTG_CSIZE-1:0] vactive;
        logic [VTG_CSIZE-1:0] vfp;
        logic [VTG_CSIZE-1:0] vsync_len;
        logic [VTG_CSIZE-1:0] vbp;
    } vtg_cfg_t;

    // 1080p60 reference raster
    localparam int VTG_1080P_HACTIVE = 1920;
    localparam int VTG_1080P_HFP     = 88;
    localparam int VTG_1080P_HSYNC   = 44;
    localparam int VTG_1080P_HBP     = 148;
    localparam int VTG_1080P_VACTIVE = 1080;
    localparam int VTG_1080P_VFP     = 4;
    localparam int VTG_1080P_VSYNC   = 5;
    localparam int VTG_1080P_VBP     = 36;
    localparam int VTG_1080P_HTOTAL  = 2200;
    localparam int VTG_1080P_VTOTAL  = 1125;

endpackage

// File: rtl/vtg_wrap_counter.sv
// vtg_wrap_counter: clearable up-counter that rolls over on a terminal value.
// o_wrap is combinational: high on the increment that returns the count to 0.
module vtg_wrap_counter
    import vtg_pkg::*;
#(
    parameter int W = VTG_CSIZE
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;

    assign o_wrap  = i_inc && (r_count == i_term);
    assign o_count = r_count;

    // Clear dominates; otherwise step and roll over on the terminal value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vdma_timing_gen.sv
// vdma_timing_gen: raster sync/DE generator for the VDMA read path.
// Define VTG_PRE_DE_EN to add the pre_de prefetch output (PRE_LEAD cycles early).
module vdma_timing_gen
    import vtg_pkg::*;
#(
    parameter string HS_POL   = VTG_POL_POS,
    parameter string VS_POL   = VTG_POL_POS,
`ifdef VTG_PRE_DE_EN
    parameter int    PRE_LEAD = 4,
`endif
    parameter int    CSIZE    = VTG_CSIZE
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [CSIZE-1:0] hactive,
    input  logic [CSIZE-1:0] hfp,
    input  logic [CSIZE-1:0] hsync_len,
    input  logic [CSIZE-1:0] hbp,
    input  logic [CSIZE-1:0] vactive,
    input  logic [CSIZE-1:0] vfp,
    input  logic [CSIZE-1:0] vsync_len,
    input  logic [CSIZE-1:0] vbp,
    output logic             out_vsync,
    output logic             out_hsync,
    output logic             out_de,
    output logic             frame_start,
    output logic             line_start,
    output logic [CSIZE-1:0] hcount,
    output logic [CSIZE-1:0] vcount,
    output logic             running,
`ifdef VTG_PRE_DE_EN
    output logic             pre_de,
`endif
    output logic             cfg_err
);

    localparam logic [1:0] S_IDLE  = VTG_IDLE;
    localparam logic [1:0] S_LATCH = VTG_LATCH;
    localparam logic [1:0] S_RUN   = VTG_RUN;

    // Totals carry two extra bits so a sum of four fields never overflows.
    localparam int TW = CSIZE + 2;
    localparam logic [TW-1:0]    TOT_MAX = {2'b01, {CSIZE{1'b0}}};
    localparam logic [CSIZE-1:0] ONE     = {{(CSIZE-1){1'b0}}, 1'b1};

    localparam logic HS_ACT = (HS_POL == VTG_POL_NEG) ? 1'b0 : 1'b1;
    localparam logic VS_ACT = (VS_POL == VTG_POL_NEG) ? 1'b0 : 1'b1;

    logic [1:0]       r_state;
    vtg_cfg_t         r_cfg;
    vtg_cfg_t         w_in_cfg;
    logic             r_cfg_err;

    logic [TW-1:0]    w_in_htotal;
    logic [TW-1:0]    w_in_vtotal;
    logic             w_in_legal;

    logic [CSIZE-1:0] w_sh_ha;
    logic [CSIZE-1:0] w_sh_hfp;
    logic [CSIZE-1:0] w_sh_hs;
    logic [CSIZE-1:0] w_sh_hbp;
    logic [CSIZE-1:0] w_sh_va;
    logic [CSIZE-1:0] w_sh_vfp;
    logic [CSIZE-1:0] w_sh_vs;
    logic [CSIZE-1:0] w_sh_vbp;

    logic [TW-1:0]    w_htotal;
    logic [TW-1:0]    w_vtotal;
    logic [CSIZE-1:0] w_hterm;
    logic [CSIZE-1:0] w_vterm;
    logic [TW-1:0]    w_hde_lo;
    logic [TW-1:0]    w_hde_hi;
    logic [TW-1:0]    w_vde_lo;
    logic [TW-1:0]    w_vde_hi;

    logic             w_run;
    logic             w_clr;
    logic [CSIZE-1:0] w_h;
    logic [CSIZE-1:0] w_v;
    logic [TW-1:0]    w_hx;
    logic [TW-1:0]    w_vx;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_frame_end;

    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_hwin;
    logic             w_vwin;

    logic             r_vsync;
    logic             r_hsync;
    logic             r_de;
    logic             r_frame_start;
    logic             r_line_start;
    logic [CSIZE-1:0] r_hcount;
    logic [CSIZE-1:0] r_vcount;
    logic             r_running;

    // Pack the live configuration inputs into the shadow layout.
    always_comb begin
        w_in_cfg           = '0;
        w_in_cfg.hactive   = VTG_CSIZE'(hactive);
        w_in_cfg.hfp       = VTG_CSIZE'(hfp);
        w_in_cfg.hsync_len = VTG_CSIZE'(hsync_len);
        w_in_cfg.hbp       = VTG_CSIZE'(hbp);
        w_in_cfg.vactive   = VTG_CSIZE'(vactive);
        w_in_cfg.vfp       = VTG_CSIZE'(vfp);
        w_in_cfg.vsync_len = VTG_CSIZE'(vsync_len);
        w_in_cfg.vbp       = VTG_CSIZE'(vbp);
    end

    assign w_in_htotal = {2'b00, hsync_len} + {2'b00, hbp}
                       + {2'b00, hactive} + {2'b00, hfp};
    assign w_in_vtotal = {2'b00, vsync_len} + {2'b00, vbp}
                       + {2'b00, vactive} + {2'b00, vfp};

    // A total of exactly 2^CSIZE still fits: the counter tops out at all-ones.
    assign w_in_legal = (hactive != '0) && (vactive != '0)
                     && (hsync_len != '0) && (vsync_len != '0)
                     && (w_in_htotal <= TOT_MAX)
                     && (w_in_vtotal <= TOT_MAX);

    assign w_sh_ha  = CSIZE'(r_cfg.hactive);
    assign w_sh_hfp = CSIZE'(r_cfg.hfp);
    assign w_sh_hs  = CSIZE'(r_cfg.hsync_len);
    assign w_sh_hbp = CSIZE'(r_cfg.hbp);
    assign w_sh_va  = CSIZE'(r_cfg.vactive);
    assign w_sh_vfp = CSIZE'(r_cfg.vfp);
    assign w_sh_vs  = CSIZE'(r_cfg.vsync_len);
    assign w_sh_vbp = CSIZE'(r_cfg.vbp);

    assign w_htotal = {2'b00, w_sh_hs} + {2'b00, w_sh_hbp}
                    + {2'b00, w_sh_ha} + {2'b00, w_sh_hfp};
    assign w_vtotal = {2'b00, w_sh_vs} + {2'b00, w_sh_vbp}
                    + {2'b00, w_sh_va} + {2'b00, w_sh_vfp};

    // Low CSIZE bits of (total - 1); exact because legal totals <= 2^CSIZE.
    assign w_hterm = w_htotal[CSIZE-1:0] - ONE;
    assign w_vterm = w_vtotal[CSIZE-1:0] - ONE;

    assign w_hde_lo = {2'b00, w_sh_hs} + {2'b00, w_sh_hbp};
    assign w_hde_hi = w_hde_lo + {2'b00, w_sh_ha};
    assign w_vde_lo = {2'b00, w_sh_vs} + {2'b00, w_sh_vbp};
    assign w_vde_hi = w_vde_lo + {2'b00, w_sh_va};

    assign w_run = (r_state == S_RUN);
    assign w_clr = !w_run;

    vtg_wrap_counter #(
        .W(CSIZE)
    ) u_hcnt (
        .i_clk   (clock),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_run),
        .i_term  (w_hterm),
        .o_count (w_h),
        .o_wrap  (w_hwrap)
    );

    vtg_wrap_counter #(
        .W(CSIZE)
    ) u_vcnt (
        .i_clk   (clock),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_inc   (w_hwrap),
        .i_term  (w_vterm),
        .o_count (w_v),
        .o_wrap  (w_vwrap)
    );

    // v only advances on an h wrap, so a v wrap marks the last pixel.
    assign w_frame_end = w_hwrap && w_vwrap;

    assign w_hx = {2'b00, w_h};
    assign w_vx = {2'b00, w_v};

    assign w_hs_act = (w_h < w_sh_hs);
    assign w_vs_act = (w_v < w_sh_vs);
    assign w_hwin   = (w_hx >= w_hde_lo) && (w_hx < w_hde_hi);
    assign w_vwin   = (w_vx >= w_vde_lo) && (w_vx < w_vde_hi);

    // Sequencer: latch/check config on start and at every frame end.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cfg     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_cfg <= w_in_cfg;
                    if (w_in_legal) begin
                        r_cfg_err <= 1'b0;
                        r_state   <= S_RUN;
                    end else begin
                        r_cfg_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_frame_end) begin
                        if (enable) begin
                            r_cfg <= w_in_cfg;
                            if (w_in_legal) begin
                                r_cfg_err <= 1'b0;
                            end else begin
                                r_cfg_err <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register every raster output one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_vsync       <= ~VS_ACT;
            r_hsync       <= ~HS_ACT;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_running     <= 1'b0;
        end else begin
            r_hsync       <= (w_run && w_hs_act) ? HS_ACT : ~HS_ACT;
            r_vsync       <= (w_run && w_vs_act) ? VS_ACT : ~VS_ACT;
            r_de          <= w_run && w_hwin && w_vwin;
            r_line_start  <= w_run && (w_h == '0);
            r_frame_start <= w_run && (w_h == '0) && (w_v == '0);
            r_hcount      <= w_h;
            r_vcount      <= w_v;
            r_running     <= w_run;
        end
    end

`ifdef VTG_PRE_DE_EN
    logic [TW-1:0] w_hpre;
    logic          w_prewin;
    logic          r_pre_de;

    // Looking ahead never crosses into the next line; h+lead below the
    // window start is simply outside it, which clips the lead at h=0.
    assign w_hpre   = w_hx + TW'(PRE_LEAD);
    assign w_prewin = (w_hpre >= w_hde_lo) && (w_hpre < w_hde_hi);

    // Prefetch strobe, same register stage as out_de.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_pre_de <= 1'b0;
        end else begin
            r_pre_de <= w_run && w_prewin && w_vwin;
        end
    end

    assign pre_de = r_pre_de;
`endif

    assign out_vsync   = r_vsync;
    assign out_hsync   = r_hsync;
    assign out_de      = r_de;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign running     = r_running;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_vdma_timing_gen.sv
// tb_vdma_timing_gen: table vectors, corner sequences and random runs
// checked every cycle against a frame-position reference model.
module tb_vdma_timing_gen;

    localparam int LEAD = 2;

    logic        clock = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] hactive, hfp, hsync_len, hbp;
    logic [15:0] vactive, vfp, vsync_len, vbp;

    logic        p_vsync, p_hsync, p_de, p_fs, p_ls, p_run, p_err;
    logic [15:0] p_hc, p_vc;
    logic        n_vsync, n_hsync, n_de, n_fs, n_ls, n_run, n_err;
    logic [15:0] n_hc, n_vc;
`ifdef VTG_PRE_DE_EN
    logic        p_pre, n_pre;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    vdma_timing_gen #(
`ifdef VTG_PRE_DE_EN
        .PRE_LEAD(LEAD),
`endif
        .HS_POL("POSITIVE"),
        .VS_POL("POSITIVE")
    ) u_pos (
        .clock(clock), .rst(rst), .enable(enable),
        .hactive(hactive), .hfp(hfp),
        .hsync_len(hsync_len), .hbp(hbp),
        .vactive(vactive), .vfp(vfp),
        .vsync_len(vsync_len), .vbp(vbp),
        .out_vsync(p_vsync), .out_hsync(p_hsync),
        .out_de(p_de), .frame_start(p_fs),
        .line_start(p_ls), .hcount(p_hc),
        .vcount(p_vc), .running(p_run),
`ifdef VTG_PRE_DE_EN
        .pre_de(p_pre),
`endif
        .cfg_err(p_err)
    );

    vdma_timing_gen #(
`ifdef VTG_PRE_DE_EN
        .PRE_LEAD(LEAD),
`endif
        .HS_POL("NEGATIVE"),
        .VS_POL("NEGATIVE")
    ) u_neg (
        .clock(clock), .rst(rst), .enable(enable),
        .hactive(hactive), .hfp(hfp),
        .hsync_len(hsync_len), .hbp(hbp),
        .vactive(vactive), .vfp(vfp),
        .vsync_len(vsync_len), .vbp(vbp),
        .out_vsync(n_vsync), .out_hsync(n_hsync),
        .out_de(n_de), .frame_start(n_fs),
        .line_start(n_ls), .hcount(n_hc),
        .vcount(n_vc), .running(n_run),
`ifdef VTG_PRE_DE_EN
        .pre_de(n_pre),
`endif
        .cfg_err(n_err)
    );

    // Reference model: mode, cycle index within the frame, shadow config.
    int     m_st;   // 0 stopped, 1 loading config, 2 generating
    longint m_k;
    bit     m_err;
    int     s_ha, s_hfp, s_hs, s_hbp;
    int     s_va, s_vfp, s_vs, s_vbp;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit legal_in();
        longint ht, vt;
        ht = longint'(hsync_len) + hbp + hactive + hfp;
        vt = longint'(vsync_len) + vbp + vactive + vfp;
        return hactive != 0 && vactive != 0 &&
               hsync_len != 0 && vsync_len != 0 &&
               ht <= 65536 && vt <= 65536;
    endfunction

    task automatic take_cfg();
        s_ha = int'(hactive);   s_hfp = int'(hfp);
        s_hs = int'(hsync_len); s_hbp = int'(hbp);
        s_va = int'(vactive);   s_vfp = int'(vfp);
        s_vs = int'(vsync_len); s_vbp = int'(vbp);
    endtask

    // One clock: predict from the pre-edge model, advance, compare at +1.
    task automatic step();
        bit r, en, ok, go;
        bit e_hs, e_vs, e_de, e_ls, e_fs, e_pre;
        longint ht, vt, h, v, hl, vl;
        r  = rst;
        en = enable;
        ok = legal_in();
        ht = s_hs + s_hbp + s_ha + s_hfp;
        vt = s_vs + s_vbp + s_va + s_vfp;
        go = !r && (m_st == 2);
        {e_hs, e_vs, e_de, e_ls, e_fs, e_pre} = '0;
        h = 0;
        v = 0;
        if (go) begin
            h    = m_k % ht;
            v    = m_k / ht;
            hl   = s_hs + s_hbp;
            vl   = s_vs + s_vbp;
            e_hs = h < s_hs;
            e_vs = v < s_vs;
            e_de = h >= hl && h < hl + s_ha &&
                   v >= vl && v < vl + s_va;
            e_pre = h + LEAD >= hl && h + LEAD < hl + s_ha &&
                    v >= vl && v < vl + s_va;
            e_ls = (h == 0);
            e_fs = (m_k == 0);
        end
        @(posedge clock);
        cyc++;
        if (r) begin
            m_st  = 0;
            m_k   = 0;
            m_err = 0;
        end else if (m_st == 0) begin
            if (en) m_st = 1;
        end else if (m_st == 1) begin
            take_cfg();
            m_err = !ok;
            m_st  = ok ? 2 : 0;
            m_k   = 0;
        end else begin
            m_k++;
            if (m_k == ht * vt) begin
                m_k = 0;
                if (en) begin
                    take_cfg();
                    m_err = !ok;
                    if (!ok) m_st = 0;
                end else begin
                    m_st = 0;
                end
            end
        end
        #1;
        chk("hsync", p_hsync, e_hs);
        chk("vsync", p_vsync, e_vs);
        chk("hsync_neg", n_hsync, !e_hs);
        chk("vsync_neg", n_vsync, !e_vs);
        chk("de", p_de, e_de);
        chk("de_neg", n_de, e_de);
        chk("line_start", p_ls, e_ls);
        chk("frame_start", p_fs, e_fs);
        chk("hcount", p_hc, h);
        chk("vcount", p_vc, v);
        chk("running", p_run, go);
        chk("cfg_err", p_err, m_err);
`ifdef VTG_PRE_DE_EN
        chk("pre_de", p_pre, e_pre);
`endif
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs,
                           input int hb, input int va, input int vf,
                           input int vs, input int vb);
        hactive   = 16'(ha); hfp = 16'(hf);
        hsync_len = 16'(hs); hbp = 16'(hb);
        vactive   = 16'(va); vfp = 16'(vf);
        vsync_len = 16'(vs); vbp = 16'(vb);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_cfg();
        set_cfg($urandom_range(0, 6), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit err;
        int frame, lines, de_off, de_n, hs_n, vs_n;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int fs_n, de_n, hs_n, vs_n, ls_n, de_off, t0, per, budget;
        int t_clr, t_fs, run_n, fs_after, pre_r, de_r;
        bit found, run_seen;
        int fs_t[$];

        // Config, then expected per-frame measurements (frame 0: none).
        tbl[0] = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 48, 6, 19, 12, 12, 8};
        tbl[1] = '{0, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{6, 2, 3, 2, 2, 1, 2, 1, 0, 78, 6, 44, 12, 18, 26};
        tbl[3] = '{4, 1, 2, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{65535, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{65533, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{2, 1, 1, 0, 65535, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 4, 2, 3, 1, 2, 2};

        m_st = 0; m_k = 0; m_err = 0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        take_cfg();
        rst = 1'b1;
        enable = 1'b0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_cfg(tbl[i].ha, tbl[i].hf, tbl[i].hs, tbl[i].hb,
                    tbl[i].va, tbl[i].vf, tbl[i].vs, tbl[i].vb);
            enable = 1'b1;
            fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0;
            de_off = -1; t0 = 0; per = 0;
            budget = tbl[i].frame > 0 ? 2 * tbl[i].frame + 10 : 12;
            for (int c = 0; c < budget; c++) begin
                step();
                if (p_fs) begin
                    if (fs_n == 0) t0 = c;
                    else if (fs_n == 1) per = c - t0;
                    fs_n++;
                end
                if (fs_n == 1) begin
                    de_n += int'(p_de);
                    hs_n += int'(p_hsync);
                    vs_n += int'(p_vsync);
                    ls_n += int'(p_ls);
                    if (p_de && de_off < 0) de_off = c - t0;
                end
            end
            chk($sformatf("vec%0d_err", i), p_err, tbl[i].err);
            chk($sformatf("vec%0d_run", i), p_run, !tbl[i].err);
            if (tbl[i].frame > 0) begin
                chk($sformatf("vec%0d_period", i), per, tbl[i].frame);
                chk($sformatf("vec%0d_lines", i), ls_n, tbl[i].lines);
                chk($sformatf("vec%0d_deoff", i), de_off, tbl[i].de_off);
                chk($sformatf("vec%0d_de_n", i), de_n, tbl[i].de_n);
                chk($sformatf("vec%0d_hs_n", i), hs_n, tbl[i].hs_n);
                chk($sformatf("vec%0d_vs_n", i), vs_n, tbl[i].vs_n);
            end
        end

        // hactive 4 -> 6 mid-frame: takes effect on the next frame only.
        do_reset();
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        enable = 1'b1;
        fs_t.delete();
        for (int c = 0; c < 180; c++) begin
            step();
            if (p_fs) fs_t.push_back(c);
            if (c == 15) hactive = 16'd6;
        end
        chk("chg_frames", fs_t.size() >= 3, 1);
        if (fs_t.size() >= 3) begin
            chk("chg_old", fs_t[1] - fs_t[0], 48);
            chk("chg_new", fs_t[2] - fs_t[1], 60);
        end

        // Drop enable at line 2: frame completes, then stops.
        do_reset();
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            found = p_fs;
        end
        chk("drop_start", found, 1);
        run_n = 1;
        for (int c = 0; c < 17; c++) begin
            step();
            run_n += int'(p_run);
        end
        enable = 1'b0;
        fs_after = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            run_n += int'(p_run);
            fs_after += int'(p_fs);
        end
        chk("drop_run_len", run_n, 48);
        chk("drop_no_fs", fs_after, 0);
        chk("drop_stopped", p_run, 0);

        // Illegal config keeps retrying; fixing it starts frames quickly.
        do_reset();
        set_cfg(0, 1, 2, 1, 3, 1, 1, 1);
        enable = 1'b1;
        run_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            run_seen |= p_run;
        end
        chk("err_set", p_err, 1);
        chk("err_norun", run_seen, 0);
        hactive = 16'd4;
        t_clr = -1;
        t_fs = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (t_clr < 0 && !p_err) t_clr = c;
            if (t_fs < 0 && p_fs) t_fs = c;
        end
        chk("err_recover",
            t_clr >= 0 && t_fs >= 0 && t_fs - t_clr <= 3, 1);

        // Reset mid-frame returns everything to reset values at once.
        do_reset();
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            step();
            found = (p_hc == 16'd4) && (p_vc == 16'd3);
        end
        chk("rst_reach", found, 1);
        rst = 1'b1;
        step();
        chk("rst_hc", p_hc, 0);
        chk("rst_vc", p_vc, 0);
        chk("rst_de", p_de, 0);
        chk("rst_hs_neg", n_hsync, 1);
        chk("rst_vs_neg", n_vsync, 1);
        chk("rst_run", p_run, 0);
        rst = 1'b0;

`ifdef VTG_PRE_DE_EN
        // Prefetch strobe leads the first DE rise by LEAD cycles.
        do_reset();
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        enable = 1'b1;
        pre_r = -1;
        de_r = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (pre_r < 0 && p_pre) pre_r = c;
            if (de_r < 0 && p_de) de_r = c;
        end
        chk("pre_lead", de_r - pre_r, LEAD);
`else
        pre_r = 0;
        de_r = 0;
`endif

        // Random configs, enable toggles and occasional resets.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rand_cfg();
            enable = 1'b1;
            for (int c = 0; c < 400; c++) begin
                step();
                if ($urandom_range(0, 99) < 2) rand_cfg();
                if ($urandom_range(0, 99) < 1) enable = ~enable;
                rst = ($urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
